matmul_compute_ctrl: RTL

// - Sequences the matrix-multiply compute phase after input_mems asserts matrices_loaded.
// - Walks every C[m][n] = sum_k A[m][k]*B[k][n] in row-major order (m outer, n, k inner).
// - Drives A_read_addr/B_read_addr and the MAC strobes (valid/init/last), then pulses compute_finished back to input_mems.
// - A stored row-major MxK (addr m*K+k); B stored row-major KxN (addr k*N+n); memory read latency is 1 cycle.

---
 rtl/matmul_compute_ctrl_if.sv | 48 ++++
 rtl/matmul_compute_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_compute_ctrl_if.sv
// Handshake and memory-address bundle between matmul_compute_ctrl (master)
// and its environment: input_mems, the A/B memories and the MAC (slave).
interface matmul_compute_ctrl_if #(
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8
);
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);

    logic                   matrices_loaded;
    logic [K_BITS-1:0]      K;
    logic                   out_ready;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic                   mac_valid;
    logic                   mac_init;
    logic                   mac_last;
    logic                   compute_finished;
    logic                   busy;

    modport master (
        input  matrices_loaded,
        input  K,
        input  out_ready,
        output A_read_addr,
        output B_read_addr,
        output mac_valid,
        output mac_init,
        output mac_last,
        output compute_finished,
        output busy
    );

    modport slave (
        output matrices_loaded,
        output K,
        output out_ready,
        input  A_read_addr,
        input  B_read_addr,
        input  mac_valid,
        input  mac_init,
        input  mac_last,
        input  compute_finished,
        input  busy
    );
endinterface

// File: rtl/matmul_compute_ctrl.sv
// Sequences the C = A*B compute phase: walks m, n, k, drives A/B read addresses and MAC strobes.
// Optional MATMUL_CTRL_STATS_EN adds saturating cycle_count / stall_count outputs.
module matmul_compute_ctrl #(
    parameter int M       = 7,
    parameter int N       = 9,
    parameter int MAXK    = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef MATMUL_CTRL_STATS_EN
    output logic [15:0]           cycle_count,
    output logic [15:0]           stall_count,
`endif
    matmul_compute_ctrl_if.master bus
);
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);
    localparam int M_BITS      = (M > 1) ? $clog2(M) : 1;
    localparam int N_BITS      = (N > 1) ? $clog2(N) : 1;
    localparam int DRAIN_BITS  = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        DRAIN,
        DONE,
        WAIT_CLR
    } state_t;

    state_t state;
    state_t state_next;

    logic [K_BITS-1:0]      k_lat;
    logic [K_BITS-1:0]      k_cnt;
    logic [M_BITS-1:0]      m_cnt;
    logic [N_BITS-1:0]      n_cnt;
    logic [A_ADDR_BITS-1:0] a_addr;
    logic [A_ADDR_BITS-1:0] a_row_base;
    logic [B_ADDR_BITS-1:0] b_addr;
    logic [DRAIN_BITS-1:0]  drain_cnt;
    logic                   mac_valid_q;
    logic                   mac_init_q;
    logic                   mac_last_q;

    logic start;
    logic start_compute;
    logic issue;
    logic k_first;
    logic k_wrap;
    logic n_wrap;
    logic m_wrap;
    logic last_pair;
    logic drain_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new dot product (k=0) only starts when downstream has room; once started it runs unstalled.
    always_comb begin
        k_first       = (k_cnt == '0);
        k_wrap        = (k_cnt == (k_lat - K_BITS'(1)));
        n_wrap        = (n_cnt == N_BITS'(N - 1));
        m_wrap        = (m_cnt == M_BITS'(M - 1));
        last_pair     = k_wrap && n_wrap && m_wrap;
        issue         = (state == COMPUTE) && (!k_first || bus.out_ready);
        drain_done    = (drain_cnt == DRAIN_BITS'(MAC_LAT));
        start         = (state == IDLE) && bus.matrices_loaded;
        start_compute = start && (bus.K != '0);
        state_next    = state;
        case (state)
            IDLE: begin
                if (bus.matrices_loaded) begin
                    state_next = (bus.K == '0) ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                if (issue && last_pair) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!bus.matrices_loaded) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Addresses advance incrementally: +1 / +N within a dot product, then jump to the next row base or column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_lat       <= '0;
            k_cnt       <= '0;
            m_cnt       <= '0;
            n_cnt       <= '0;
            a_addr      <= '0;
            a_row_base  <= '0;
            b_addr      <= '0;
            mac_valid_q <= 1'b0;
            mac_init_q  <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            mac_valid_q <= issue;
            mac_init_q  <= issue && k_first;
            mac_last_q  <= issue && k_wrap;
            if (start) begin
                k_lat <= bus.K;
            end
            if (start_compute) begin
                k_cnt      <= '0;
                m_cnt      <= '0;
                n_cnt      <= '0;
                a_addr     <= '0;
                a_row_base <= '0;
                b_addr     <= '0;
            end else if (issue && !last_pair) begin
                if (k_wrap) begin
                    k_cnt <= '0;
                    if (n_wrap) begin
                        n_cnt      <= '0;
                        m_cnt      <= m_cnt + M_BITS'(1);
                        a_row_base <= a_row_base + A_ADDR_BITS'(k_lat);
                        a_addr     <= a_row_base + A_ADDR_BITS'(k_lat);
                        b_addr     <= '0;
                    end else begin
                        n_cnt  <= n_cnt + N_BITS'(1);
                        a_addr <= a_row_base;
                        b_addr <= B_ADDR_BITS'(n_cnt) + B_ADDR_BITS'(1);
                    end
                end else begin
                    k_cnt  <= k_cnt + K_BITS'(1);
                    a_addr <= a_addr + A_ADDR_BITS'(1);
                    b_addr <= b_addr + B_ADDR_BITS'(N);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DRAIN_BITS'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

`ifdef MATMUL_CTRL_STATS_EN
    // Counters restart with every batch (including K=0) and saturate rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else if (start) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            if ((state == COMPUTE || state == DRAIN || state == DONE) && (cycle_count != 16'hFFFF)) begin
                cycle_count <= cycle_count + 16'd1;
            end
            if ((state == COMPUTE) && k_first && !bus.out_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

    assign bus.A_read_addr      = a_addr;
    assign bus.B_read_addr      = b_addr;
    assign bus.mac_valid        = mac_valid_q;
    assign bus.mac_init         = mac_init_q;
    assign bus.mac_last         = mac_last_q;
    assign bus.compute_finished = (state == DONE);
    assign bus.busy             = (state != IDLE);

endmodule
